// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage_pkg
//  Purpose  : Shared definitions for the execute stage. Contains the bus
//             widths, the aluop codes for the supported operations, the
//             alusel result classes and the divider state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  // Bus widths (RegBus, RegAddrBus, AluOpBus, AluSelBus)
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 8;
  localparam int SEL_W  = 3;

  localparam logic [DATA_W-1:0] ZeroWord = '0;

  // aluop codes
  localparam logic [OP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [OP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [OP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [OP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [OP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [OP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [OP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [OP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [OP_W-1:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [OP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [OP_W-1:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [OP_W-1:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [OP_W-1:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [OP_W-1:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  // alusel result classes
  localparam logic [SEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [SEL_W-1:0] EXE_RES_ARITH = 3'b100;

  // Divider FSM encoding
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
//  Module   : ex_div
//  Purpose  : Iterative radix-2 restoring divider, one quotient bit per cycle.
//             Signed mode divides magnitudes and fixes signs at the output.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             start            - divide requested (sampled in IDLE)
//             signed_div       - 1 = DIV, 0 = DIVU
//             opdata1/opdata2  - dividend / divisor
//             annul            - abort any divide, return to IDLE
//             hold             - keep DONE (and the result) while asserted
//             result           - {remainder, quotient}, zero outside DONE
//             ready            - high while in DONE
//  Revision : 1.0 - initial release
// ============================================================================
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  input  logic                annul,
  input  logic                hold,
  output logic [2*DATA_W-1:0] result,
  output logic                ready
);

  localparam int         SR_W      = 2*DATA_W + 1;
  localparam logic [5:0] LAST_STEP = 6'(DATA_W - 1);

  div_state_e        state_q;
  logic [5:0]        cnt_q;
  logic [SR_W-1:0]   sr_q;
  logic [DATA_W-1:0] divisor_q;
  logic              neg_quot_q;
  logic              neg_rem_q;

  // Operand magnitudes for issue; the most negative value maps onto itself,
  // which is still the correct magnitude when read as unsigned.
  logic              w_a_neg, w_b_neg;
  logic [DATA_W-1:0] w_abs_a, w_abs_b;

  assign w_a_neg = signed_div & opdata1[DATA_W-1];
  assign w_b_neg = signed_div & opdata2[DATA_W-1];
  assign w_abs_a = w_a_neg ? -opdata1 : opdata1;
  assign w_abs_b = w_b_neg ? -opdata2 : opdata2;

  // Shift register layout: [SR_W-1:DATA_W+1] partial remainder,
  // [DATA_W:1] unconsumed dividend bits, quotient bits enter at [0].
  // The trial window [SR_W-1:DATA_W] is one bit wider than the divisor so
  // that divisors with the MSB set are handled correctly.
  logic              w_fits;
  logic [DATA_W-1:0] w_diff;
  logic [SR_W-1:0]   sr_d;

  assign w_fits = sr_q[SR_W-1:DATA_W] >= {1'b0, divisor_q};
  // When the divisor fits, the difference is below the divisor, so the
  // low DATA_W bits of the subtraction are the complete new remainder.
  assign w_diff = sr_q[SR_W-2:DATA_W] - divisor_q;
  assign sr_d   = w_fits ? {w_diff, sr_q[DATA_W-1:0], 1'b1}
                         : {sr_q[SR_W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (annul) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            if (opdata2 == '0) begin
              // Divide by zero: no iterations, result reads as zero.
              sr_q       <= '0;
              neg_quot_q <= 1'b0;
              neg_rem_q  <= 1'b0;
              state_q    <= DIV_DONE;
            end else begin
              sr_q       <= {{DATA_W{1'b0}}, w_abs_a, 1'b0};
              divisor_q  <= w_abs_b;
              neg_quot_q <= w_a_neg ^ w_b_neg;
              neg_rem_q  <= w_a_neg;
              cnt_q      <= '0;
              state_q    <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) begin
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!hold) begin
            state_q <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] w_quot, w_rem;

  assign w_quot = neg_quot_q ? -sr_q[DATA_W-1:0] : sr_q[DATA_W-1:0];
  assign w_rem  = neg_rem_q  ? -sr_q[SR_W-1:DATA_W+1] : sr_q[SR_W-1:DATA_W+1];

  assign ready  = (state_q == DIV_DONE);
  assign result = ready ? {w_rem, w_quot} : '0;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : Pipeline execute stage. Combinational logic/shift/arith ALU
//             selected by alusel, plus the iterative divider for DIV/DIVU
//             and the stall/HI-LO write glue around it.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             ex_aluop, ex_alusel   - operation and result class from ID/EX
//             ex_reg1, ex_reg2      - operands (dividend, divisor)
//             ex_wd, ex_wreg        - destination and write enable
//             stall_hold            - keep a finished divide result
//             flush                 - abort an in-flight divide
//             wd_o, wreg_o, wdata_o - EX/MEM GPR write
//             hi_o, lo_o, whilo_o   - divide remainder/quotient and write
//             stallreq              - freeze request while dividing
//  Revision : 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   ex_aluop,
  input  logic [SEL_W-1:0]  ex_alusel,
  input  logic [DATA_W-1:0] ex_reg1,
  input  logic [DATA_W-1:0] ex_reg2,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic              stall_hold,
  input  logic              flush,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              whilo_o,
  output logic              stallreq
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] w_logic_res, w_shift_res, w_arith_res;
  logic [SH_W-1:0]   w_shamt;

  // Shift amount comes from operand 1, the shifted value from operand 2.
  assign w_shamt = ex_reg1[SH_W-1:0];

  always_comb begin
    w_logic_res = '0;
    w_shift_res = '0;
    w_arith_res = '0;
    case (ex_aluop)
      EXE_AND_OP:  w_logic_res = ex_reg1 & ex_reg2;
      EXE_OR_OP:   w_logic_res = ex_reg1 | ex_reg2;
      EXE_XOR_OP:  w_logic_res = ex_reg1 ^ ex_reg2;
      EXE_NOR_OP:  w_logic_res = ~(ex_reg1 | ex_reg2);
      EXE_SLL_OP:  w_shift_res = ex_reg2 << w_shamt;
      EXE_SRL_OP:  w_shift_res = ex_reg2 >> w_shamt;
      EXE_SRA_OP:  w_shift_res = $signed(ex_reg2) >>> w_shamt;
      EXE_ADD_OP,
      EXE_ADDU_OP: w_arith_res = ex_reg1 + ex_reg2;
      EXE_SUB_OP,
      EXE_SUBU_OP: w_arith_res = ex_reg1 - ex_reg2;
      EXE_SLT_OP:  w_arith_res = {{(DATA_W-1){1'b0}}, ($signed(ex_reg1) < $signed(ex_reg2))};
      EXE_SLTU_OP: w_arith_res = {{(DATA_W-1){1'b0}}, (ex_reg1 < ex_reg2)};
      default: ;
    endcase
  end

  always_comb begin
    case (ex_alusel)
      EXE_RES_LOGIC: wdata_o = w_logic_res;
      EXE_RES_SHIFT: wdata_o = w_shift_res;
      EXE_RES_ARITH: wdata_o = w_arith_res;
      default:       wdata_o = '0;
    endcase
  end

  assign wd_o   = ex_wd;
  assign wreg_o = ex_wreg;

  logic                w_div_op;
  logic                w_div_ready;
  logic [2*DATA_W-1:0] w_div_result;

  assign w_div_op = (ex_aluop == EXE_DIV_OP) || (ex_aluop == EXE_DIVU_OP);

  ex_div #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (w_div_op),
    .signed_div (ex_aluop == EXE_DIV_OP),
    .opdata1    (ex_reg1),
    .opdata2    (ex_reg2),
    .annul      (flush),
    .hold       (stall_hold),
    .result     (w_div_result),
    .ready      (w_div_ready)
  );

  // The divide op stays on ID/EX while the pipe is frozen, so the request
  // naturally covers the issue cycle and every BUSY cycle, and drops in DONE.
  assign stallreq = w_div_op & ~w_div_ready & ~flush & ~rst;
  assign whilo_o  = w_div_ready;
  assign hi_o     = w_div_result[2*DATA_W-1:DATA_W];
  assign lo_o     = w_div_result[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Self-checking bench for ex_stage with random ALU and divide
//             traffic compared against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic        stall_hold;
  logic        flush;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        whilo_o;
  logic        stallreq;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .ex_aluop   (aluop),
    .ex_alusel  (alusel),
    .ex_reg1    (reg1),
    .ex_reg2    (reg2),
    .ex_wd      (wd),
    .ex_wreg    (wreg),
    .stall_hold (stall_hold),
    .flush      (flush),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .whilo_o    (whilo_o),
    .stallreq   (stallreq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] op_class(input logic [7:0] op);
    case (op)
      EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP:            return EXE_RES_LOGIC;
      EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:                       return EXE_RES_SHIFT;
      EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP,
      EXE_SLT_OP, EXE_SLTU_OP:                                  return EXE_RES_ARITH;
      default:                                                  return EXE_RES_NOP;
    endcase
  endfunction

  function automatic logic [31:0] op_value(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      EXE_AND_OP:  return a & b;
      EXE_OR_OP:   return a | b;
      EXE_XOR_OP:  return a ^ b;
      EXE_NOR_OP:  return ~(a | b);
      EXE_SLL_OP:  return b << a[4:0];
      EXE_SRL_OP:  return b >> a[4:0];
      EXE_SRA_OP:  return 32'(sb >>> a[4:0]);
      EXE_ADD_OP, EXE_ADDU_OP: return a + b;
      EXE_SUB_OP, EXE_SUBU_OP: return a - b;
      EXE_SLT_OP:  return (sa < sb) ? 32'd1 : 32'd0;
      EXE_SLTU_OP: return (a < b) ? 32'd1 : 32'd0;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
    if (sel != EXE_RES_NOP && sel == op_class(op)) return op_value(op, a, b);
    return 32'd0;
  endfunction

  task automatic div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      // 64-bit arithmetic: truncating division, remainder follows dividend;
      // the MIN / -1 quotient wraps back to MIN when cut to 32 bits.
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endtask

  // ---------------- divide transaction ----------------
  // Entered away from the clock edge; leaves the DUT back in IDLE with NOP.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold_cyc, input string tag);
    logic [31:0] eq, er;
    int n, exp_n;
    div_model(sgn, a, b, eq, er);
    exp_n  = (b == 32'd0) ? 1 : 33;
    aluop  = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
    alusel = EXE_RES_NOP;
    reg1   = a;
    reg2   = b;
    #1;
    n = 0;
    while (stallreq === 1'b1 && n < 100) begin
      if (n == 0) check({tag, " whilo while stalled"}, 64'(whilo_o), 64'd0);
      n++;
      // Operands must have been latched at issue.
      if (n == 3) begin
        reg1 = $urandom;
        reg2 = $urandom;
      end
      @(posedge clk);
      #2;
    end
    check({tag, " stall cycles"}, 64'(n), 64'(exp_n));
    check({tag, " whilo"}, 64'(whilo_o), 64'd1);
    check({tag, " lo"}, 64'(lo_o), 64'(eq));
    check({tag, " hi"}, 64'(hi_o), 64'(er));
    if (hold_cyc > 0) begin
      stall_hold = 1'b1;
      for (int i = 0; i < hold_cyc; i++) begin
        @(posedge clk);
        #2;
        check({tag, " held whilo"}, 64'(whilo_o), 64'd1);
        check({tag, " held lo"}, 64'(lo_o), 64'(eq));
        check({tag, " held hi"}, 64'(hi_o), 64'(er));
        check({tag, " held stallreq"}, 64'(stallreq), 64'd0);
      end
      stall_hold = 1'b0;
    end
    aluop  = EXE_NOP_OP;
    alusel = EXE_RES_NOP;
    @(posedge clk);
    #2;
    check({tag, " whilo after done"}, 64'(whilo_o), 64'd0);
    check({tag, " lo after done"}, 64'(lo_o), 64'd0);
  endtask

  logic [7:0] alu_ops [13] = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP,
                               EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
                               EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP,
                               EXE_SLT_OP, EXE_SLTU_OP};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int whilo_seen;
    rst        = 1'b1;
    aluop      = EXE_NOP_OP;
    alusel     = EXE_RES_NOP;
    reg1       = '0;
    reg2       = '0;
    wd         = '0;
    wreg       = 1'b0;
    stall_hold = 1'b0;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset stallreq", 64'(stallreq), 64'd0);
    check("reset whilo", 64'(whilo_o), 64'd0);
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);

    // ADD 5 + 7
    aluop  = EXE_ADD_OP;
    alusel = EXE_RES_ARITH;
    reg1   = 32'd5;
    reg2   = 32'd7;
    #1;
    check("add wdata", 64'(wdata_o), 64'd12);
    check("add stallreq", 64'(stallreq), 64'd0);

    // Random ALU traffic, including mismatched alusel and unknown opcodes
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 13);
      aluop  = (k == 13) ? 8'hEE : alu_ops[k];
      alusel = ($urandom_range(0, 3) == 0 || k == 13) ? 3'($urandom) : op_class(aluop);
      reg1   = $urandom;
      reg2   = ($urandom_range(0, 3) == 0) ? reg1 : $urandom;
      wd     = 5'($urandom);
      wreg   = 1'($urandom);
      #1;
      check("alu wdata", 64'(wdata_o), 64'(alu_model(aluop, alusel, reg1, reg2)));
      check("alu wd", 64'(wd_o), 64'(wd));
      check("alu wreg", 64'(wreg_o), 64'(wreg));
      check("alu stallreq", 64'(stallreq), 64'd0);
      @(posedge clk);
      #2;
    end
    aluop  = EXE_NOP_OP;
    alusel = EXE_RES_NOP;
    #1;
    check("nop wdata", 64'(wdata_o), 64'd0);

    // Directed divides
    run_div(1'b0, 32'd7, 32'd2, 0, "divu 7/2");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2");
    run_div(1'b1, 32'd1234, 32'd0, 0, "div x/0");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div min/-1");
    run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, "divu big divisor");
    run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 0, "div 100/-7");

    // Random divides, back to back
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) b = -b;
      run_div(1'($urandom), a, b, 0, "rand div");
    end

    // Flush in BUSY
    aluop = EXE_DIVU_OP;
    reg1  = 32'd100;
    reg2  = 32'd7;
    #1;
    check("flush issue stallreq", 64'(stallreq), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check("flush busy stallreq", 64'(stallreq), 64'd1);
    flush = 1'b1;
    #1;
    check("flush same-cycle stallreq", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    aluop = EXE_NOP_OP;
    #1;
    check("flush idle stallreq", 64'(stallreq), 64'd0);
    check("flush idle whilo", 64'(whilo_o), 64'd0);
    whilo_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (whilo_o === 1'b1) whilo_seen++;
    end
    check("flush no late result", 64'(whilo_seen), 64'd0);
    #1;
    run_div(1'b0, 32'd9, 32'd3, 0, "divu 9/3 after flush");

    // Reset in BUSY
    aluop = EXE_DIV_OP;
    reg1  = 32'hFFFF_FF9C;
    reg2  = 32'd3;
    repeat (6) @(posedge clk);
    #1;
    check("rst busy stallreq", 64'(stallreq), 64'd1);
    rst = 1'b1;
    #1;
    check("rst same-cycle stallreq", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    aluop = EXE_NOP_OP;
    #1;
    check("rst stallreq", 64'(stallreq), 64'd0);
    check("rst whilo", 64'(whilo_o), 64'd0);
    check("rst hi", 64'(hi_o), 64'd0);
    check("rst lo", 64'(lo_o), 64'd0);
    whilo_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (whilo_o === 1'b1) whilo_seen++;
    end
    check("rst no late result", 64'(whilo_seen), 64'd0);
    #1;
    run_div(1'b1, 32'hFFFF_FF9C, 32'd3, 4, "div -100/3 hold4");
    run_div(1'b0, 32'd0, 32'd0, 2, "divu 0/0 hold2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
